// File: rtl/acq_flux_recorder_pkg.sv
// Shared constants and writer FSM encoding for the flux recorder.
// Imported by acq_byte_fifo and acq_flux_recorder.
package acq_pkg;

   // Byte meaning "127 sample ticks elapsed with no flux edge"
   localparam logic [7:0] ACQ_CARRY_BYTE = 8'h7F;
   localparam logic [6:0] ACQ_CNT_MAX    = 7'd126;
   localparam int         ACQ_IDX_BIT    = 7;

   typedef enum logic [1:0] {
      W_IDLE = 2'b00,
      W_REQ  = 2'b01
   } wr_state_t;

endpackage

// File: rtl/acq_byte_fifo.sv
// First-word fall-through byte FIFO between encoder and RAM writer.
// Ports: clk, rst (sync, high), push/din, pop/dout, empty, full, flush.
module acq_byte_fifo
   import acq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic [7:0] din,
   input  logic       pop,
   output logic [7:0] dout,
   output logic       empty,
   output logic       full,
   input  logic       flush
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [7:0]    r_mem [DEPTH];
   logic [PW-1:0] r_wp;
   logic [PW-1:0] r_rp;
   logic [PW:0]   r_cnt;
   logic          w_pop;
   logic          w_push;

   assign empty = (r_cnt == '0);
   assign full  = (r_cnt == FULL_CNT);
   assign dout  = r_mem[r_rp];

   // A pop in the same cycle frees the slot for a push into a full FIFO
   assign w_pop  = pop & ~empty;
   assign w_push = push & (~full | w_pop);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wp] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop)  r_rp <= r_rp + 1'b1;
         unique case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/acq_flux_recorder.sv
// Flux interval encoder + RAM writer for the acquisition path.
// Ports: clock/reset, sample tick, acq window, rd/index inputs, RAM req/ack, status.
module acq_flux_recorder
   import acq_pkg::*;
#(
   parameter int ADDR_W     = 19,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              CLK_MASTER,
   input  logic              RESET,
   input  logic              CKE_SAMPLE,
   input  logic              ACQUIRING,
   input  logic              FD_RDDATA_IN,
   input  logic              FD_INDEX_IN,
   input  logic              ADDR_CLR,
   output logic [ADDR_W-1:0] RAM_ADDR,
   output logic [7:0]        RAM_DATA,
   output logic              RAM_WR_REQ,
   input  logic              RAM_WR_ACK,
   output logic              SR_R_FULL,
   output logic              OVERRUN
);

   logic              r_rd_q;
   logic              r_idx_q;
   logic [6:0]        r_cnt;
   logic              r_idx_pend;
   logic              r_ovr;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_data;
   logic              r_req;
   logic              r_full;
   wr_state_t         r_state;

   logic       w_rd_edge;
   logic       w_idx_edge;
   logic       w_emit;
   logic [7:0] w_byte;
   logic       w_push;
   logic       w_pop;
   logic       w_flush;
   logic       w_empty;
   logic       w_ff_full;
   logic [7:0] w_dout;

   assign w_rd_edge  = FD_RDDATA_IN & ~r_rd_q;
   assign w_idx_edge = FD_INDEX_IN & ~r_idx_q;

   always_comb begin
      w_emit = 1'b0;
      w_byte = ACQ_CARRY_BYTE;
      if (ACQUIRING) begin
         if (w_rd_edge) begin
            w_emit              = 1'b1;
            w_byte              = {1'b0, r_cnt};
            w_byte[ACQ_IDX_BIT] = r_idx_pend | w_idx_edge;
         end else if (CKE_SAMPLE && r_cnt == ACQ_CNT_MAX) begin
            w_emit = 1'b1;
         end
      end
   end

   // Once full, the FIFO is held flushed so late bytes vanish silently
   assign w_flush = ADDR_CLR | r_full;
   assign w_push  = w_emit & ~r_full & ~ADDR_CLR;
   assign w_pop   = (r_state == W_IDLE) & ~w_empty
                  & ~r_full & ~ADDR_CLR;

   acq_byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (CLK_MASTER),
      .rst   (RESET),
      .push  (w_push),
      .din   (w_byte),
      .pop   (w_pop),
      .dout  (w_dout),
      .empty (w_empty),
      .full  (w_ff_full),
      .flush (w_flush)
   );

   always_ff @(posedge CLK_MASTER) begin
      if (RESET) begin
         r_rd_q     <= 1'b0;
         r_idx_q    <= 1'b0;
         r_cnt      <= '0;
         r_idx_pend <= 1'b0;
         r_ovr      <= 1'b0;
      end else begin
         r_rd_q  <= FD_RDDATA_IN;
         r_idx_q <= FD_INDEX_IN;
         if (ADDR_CLR) begin
            r_ovr <= 1'b0;
         end else if (w_push && w_ff_full && !w_pop) begin
            r_ovr <= 1'b1;
         end
         if (!ACQUIRING) begin
            r_cnt      <= '0;
            r_idx_pend <= 1'b0;
         end else if (w_rd_edge) begin
            // Any coincident sample tick is discarded
            r_cnt      <= '0;
            r_idx_pend <= 1'b0;
         end else begin
            r_idx_pend <= r_idx_pend | w_idx_edge;
            if (CKE_SAMPLE) begin
               r_cnt <= (r_cnt == ACQ_CNT_MAX) ? 7'd0 : r_cnt + 7'd1;
            end
         end
      end
   end

   always_ff @(posedge CLK_MASTER) begin
      if (RESET) begin
         r_addr  <= '0;
         r_data  <= '0;
         r_req   <= 1'b0;
         r_full  <= 1'b0;
         r_state <= W_IDLE;
      end else if (ADDR_CLR) begin
         r_addr  <= '0;
         r_req   <= 1'b0;
         r_full  <= 1'b0;
         r_state <= W_IDLE;
      end else begin
         unique case (r_state)
            W_IDLE: begin
               if (!w_empty && !r_full) begin
                  r_data  <= w_dout;
                  r_req   <= 1'b1;
                  r_state <= W_REQ;
               end
            end
            W_REQ: begin
               if (RAM_WR_ACK) begin
                  if (&r_addr) r_full <= 1'b1;
                  else         r_addr <= r_addr + 1'b1;
                  r_req   <= 1'b0;
                  r_state <= W_IDLE;
               end
            end
            default: begin
               r_req   <= 1'b0;
               r_state <= W_IDLE;
            end
         endcase
      end
   end

   assign RAM_ADDR   = r_addr;
   assign RAM_DATA   = r_data;
   assign RAM_WR_REQ = r_req;
   assign SR_R_FULL  = r_full;
   assign OVERRUN    = r_ovr;

endmodule

// File: tb/tb_acq_flux_recorder.sv
// Directed bench for acq_flux_recorder with a small RAM responder.
// Runs with ADDR_W=4 so the full-RAM boundary is reachable.
module tb_acq_flux_recorder;

   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cke = 1'b0;
   logic          acq = 1'b0;
   logic          rd = 1'b0;
   logic          idx = 1'b0;
   logic          aclr = 1'b0;
   logic          ack = 1'b0;
   logic [AW-1:0] o_addr;
   logic [7:0]    o_data;
   logic          o_req;
   logic          o_full;
   logic          o_ovr;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [AW-1:0] log_addr[$];
   logic [7:0]    log_data[$];
   bit            ack_en = 1'b1;
   bit            req_seen = 1'b0;
   int            req_cyc = 0;

   acq_flux_recorder #(
      .ADDR_W     (AW),
      .FIFO_DEPTH (4)
   ) dut (
      .CLK_MASTER   (clk),
      .RESET        (rst),
      .CKE_SAMPLE   (cke),
      .ACQUIRING    (acq),
      .FD_RDDATA_IN (rd),
      .FD_INDEX_IN  (idx),
      .ADDR_CLR     (aclr),
      .RAM_ADDR     (o_addr),
      .RAM_DATA     (o_data),
      .RAM_WR_REQ   (o_req),
      .RAM_WR_ACK   (ack),
      .SR_R_FULL    (o_full),
      .OVERRUN      (o_ovr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // RAM model: single-cycle ACK one cycle after REQ is seen
   always @(posedge clk) begin
      #2;
      if (rst) begin
         ack = 1'b0;
      end else if (ack) begin
         ack = 1'b0;
      end else if (o_req && ack_en) begin
         ack = 1'b1;
         log_addr.push_back(o_addr);
         log_data.push_back(o_data);
      end
      if (o_req && !req_seen) begin
         req_seen = 1'b1;
         req_cyc  = cyc;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_rd();
      rd = 1'b1;
      step(1);
      rd = 1'b0;
   endtask

   task automatic prep();
      acq  = 1'b0;
      aclr = 1'b1;
      step(1);
      aclr = 1'b0;
      step(1);
      log_addr.delete();
      log_data.delete();
      req_seen = 1'b0;
   endtask

   task automatic wait_writes(input int n, input int budget);
      int b;
      b = 0;
      while (log_data.size() < n && b < budget) begin
         step(1);
         b++;
      end
      checks++;
      if (log_data.size() < n) begin
         errors++;
         $display("FAIL wait_writes got %0d writes expected %0d",
                  log_data.size(), n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(3);
      checks++;
      if ({o_req, o_full, o_ovr} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags got %b expected 000",
                  {o_req, o_full, o_ovr});
      end
      checks++;
      if (o_addr !== 4'd0 || o_data !== 8'd0) begin
         errors++;
         $display("FAIL reset_bus got %h/%h expected 0/00",
                  o_addr, o_data);
      end
      rst = 1'b0;
      step(1);
   endtask

   task automatic test_single_edge();
      int edge_cyc;
      prep();
      acq = 1'b1;
      cke = 1'b1;
      step(10);
      edge_cyc = cyc;
      pulse_rd();
      wait_writes(1, 20);
      checks++;
      if (log_data.size() > 0 && log_data[0] !== 8'h0A) begin
         errors++;
         $display("FAIL single_data got %h expected 0a", log_data[0]);
      end
      checks++;
      if (log_addr.size() > 0 && log_addr[0] !== 4'd0) begin
         errors++;
         $display("FAIL single_addr got %h expected 0", log_addr[0]);
      end
      checks++;
      if (req_cyc - edge_cyc !== 2) begin
         errors++;
         $display("FAIL single_latency got %0d expected 2",
                  req_cyc - edge_cyc);
      end
   endtask

   task automatic test_carry();
      logic [7:0] exp_d[3];
      exp_d = '{8'h7F, 8'h7F, 8'h2E};
      prep();
      acq = 1'b1;
      cke = 1'b1;
      step(300);
      pulse_rd();
      wait_writes(3, 30);
      step(4);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (log_data.size() > i &&
             (log_data[i] !== exp_d[i] || log_addr[i] !== AW'(i))) begin
            errors++;
            $display("FAIL carry_%0d got %h@%h expected %h@%h", i,
                     log_data[i], log_addr[i], exp_d[i], i);
         end
      end
      checks++;
      if (o_addr !== 4'd3 || o_ovr !== 1'b0) begin
         errors++;
         $display("FAIL carry_end got addr %h ovr %b expected 3 0",
                  o_addr, o_ovr);
      end
   endtask

   task automatic test_index();
      prep();
      acq = 1'b1;
      cke = 1'b1;
      step(2);
      idx = 1'b1;
      step(1);
      idx = 1'b0;
      step(2);
      pulse_rd();
      step(2);
      pulse_rd();
      wait_writes(2, 20);
      checks++;
      if (log_data.size() > 0 && log_data[0] !== 8'h85) begin
         errors++;
         $display("FAIL index_flag got %h expected 85", log_data[0]);
      end
      checks++;
      if (log_data.size() > 1 && log_data[1] !== 8'h02) begin
         errors++;
         $display("FAIL index_clear got %h expected 02", log_data[1]);
      end
   endtask

   task automatic test_full();
      int  k;
      bit  saw_req;
      prep();
      acq = 1'b1;
      cke = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step(2 + (i % 4));
         pulse_rd();
      end
      wait_writes(16, 100);
      step(2);
      for (int i = 0; i < 16; i++) begin
         k = 2 + (i % 4);
         checks++;
         if (log_data.size() > i &&
             (log_data[i] !== 8'(k) || log_addr[i] !== AW'(i))) begin
            errors++;
            $display("FAIL full_wr_%0d got %h@%h expected %h@%h", i,
                     log_data[i], log_addr[i], k, i);
         end
      end
      checks++;
      if (o_full !== 1'b1 || o_addr !== 4'hF) begin
         errors++;
         $display("FAIL full_flag got %b@%h expected 1@f",
                  o_full, o_addr);
      end
      saw_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(3);
         pulse_rd();
         for (int j = 0; j < 5; j++) begin
            if (o_req) saw_req = 1'b1;
            step(1);
         end
      end
      checks++;
      if (saw_req || log_data.size() != 16 || o_ovr !== 1'b0) begin
         errors++;
         $display("FAIL full_block got req %b n %0d ovr %b expected 0 16 0",
                  saw_req, log_data.size(), o_ovr);
      end
      acq  = 1'b0;
      aclr = 1'b1;
      step(1);
      aclr = 1'b0;
      checks++;
      if (o_full !== 1'b0 || o_addr !== 4'd0) begin
         errors++;
         $display("FAIL full_clr got %b@%h expected 0@0", o_full, o_addr);
      end
      log_addr.delete();
      log_data.delete();
      acq = 1'b1;
      step(7);
      pulse_rd();
      wait_writes(1, 20);
      checks++;
      if (log_data.size() > 0 &&
          (log_data[0] !== 8'h07 || log_addr[0] !== 4'd0)) begin
         errors++;
         $display("FAIL full_rewrite got %h@%h expected 07@0",
                  log_data[0], log_addr[0]);
      end
   endtask

   task automatic test_overrun();
      prep();
      ack_en = 1'b0;
      cke    = 1'b1;
      acq    = 1'b1;
      pulse_rd();
      for (int k = 1; k <= 4; k++) begin
         step(k);
         pulse_rd();
      end
      checks++;
      if (o_ovr !== 1'b0) begin
         errors++;
         $display("FAIL ovr_early got %b expected 0", o_ovr);
      end
      step(5);
      pulse_rd();
      checks++;
      if (o_ovr !== 1'b1) begin
         errors++;
         $display("FAIL ovr_set got %b expected 1", o_ovr);
      end
      step(4);
      ack_en = 1'b1;
      wait_writes(5, 40);
      step(10);
      checks++;
      if (log_data.size() != 5) begin
         errors++;
         $display("FAIL ovr_count got %0d expected 5", log_data.size());
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (log_data.size() > i &&
             (log_data[i] !== 8'(i) || log_addr[i] !== AW'(i))) begin
            errors++;
            $display("FAIL ovr_wr_%0d got %h@%h expected %h@%h", i,
                     log_data[i], log_addr[i], i, i);
         end
      end
   endtask

   task automatic test_reset_mid();
      int b;
      prep();
      ack_en = 1'b1;
      acq    = 1'b1;
      cke    = 1'b1;
      step(3);
      pulse_rd();
      wait_writes(1, 20);
      ack_en = 1'b0;
      step(2);
      pulse_rd();
      b = 0;
      while (!o_req && b < 20) begin
         step(1);
         b++;
      end
      checks++;
      if (o_req !== 1'b1 || o_addr !== 4'd1) begin
         errors++;
         $display("FAIL mid_req got %b@%h expected 1@1", o_req, o_addr);
      end
      rst = 1'b1;
      step(1);
      checks++;
      if (o_req !== 1'b0 || o_addr !== 4'd0 || o_full !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset got %b/%h/%b expected 0/0/0",
                  o_req, o_addr, o_full);
      end
      rst = 1'b0;
      acq = 1'b0;
      step(1);
      log_addr.delete();
      log_data.delete();
      ack_en = 1'b1;
      acq    = 1'b1;
      step(4);
      pulse_rd();
      step(3);
      pulse_rd();
      wait_writes(2, 20);
      checks++;
      if (log_data.size() > 1 &&
          (log_data[0] !== 8'h04 || log_data[1] !== 8'h03)) begin
         errors++;
         $display("FAIL tick_prio got %h %h expected 04 03",
                  log_data[0], log_data[1]);
      end
      checks++;
      if (log_addr.size() > 1 &&
          (log_addr[0] !== 4'd0 || log_addr[1] !== 4'd1)) begin
         errors++;
         $display("FAIL tick_addr got %h %h expected 0 1",
                  log_addr[0], log_addr[1]);
      end
   endtask

   initial begin
      test_reset();
      test_single_edge();
      test_carry();
      test_index();
      test_full();
      test_overrun();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
